// File: rtl/operand_fetch.sv
// operand_fetch: 8x16 register file plus a two-step operand staging FSM
// (IDLE -> READ_A -> READ_B -> HOLD) that feeds Ain/Bin to the ALU under
// a valid/ready handshake.
// Optional feature macro: OPFETCH_BYPASS_EN. When it is defined, a write that
// targets the register being read in READ_A/READ_B is forwarded into A/B.
// When it is undefined, A/B load the contents from before the write.
module operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  rn,
  input  logic [2:0]  rm,
  input  logic [1:0]  shift,
  input  logic        asel,
  input  logic        bsel,
  input  logic [15:0] imm,
  input  logic        write,
  input  logic [2:0]  wnum,
  input  logic [15:0] wdata,
  input  logic        ready,
  output logic        valid,
  output logic        busy,
  output logic [15:0] Ain,
  output logic [15:0] Bin
);

  typedef enum logic [1:0] {IDLE, READ_A, READ_B, HOLD} state_t;

  // Request fields captured on an accepted start.
  typedef struct packed {
    logic [2:0]  rn;
    logic [2:0]  rm;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [15:0] imm;
  } req_t;

  state_t           state, state_nx;
  req_t             req_q;
  logic [7:0][15:0] rf;
  logic [15:0]      a_q, b_q;
  logic [2:0]       rd_num;
  logic [15:0]      rd_data;
  logic [15:0]      b_shifted;
  logic             accept, load_a, load_b;

  // Next-state and per-state strobes; start is only looked at in IDLE.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    load_a   = 1'b0;
    load_b   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = READ_A;
        end
      end
      READ_A: begin
        load_a   = 1'b1;
        state_nx = READ_B;
      end
      READ_B: begin
        load_b   = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        if (ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Single read port: rn in READ_A, rm in READ_B, optionally bypassing a
  // same-cycle write to the same register.
  always_comb begin
    rd_num  = (state == READ_B) ? req_q.rm : req_q.rn;
    rd_data = rf[rd_num];
`ifdef OPFETCH_BYPASS_EN
    if (write && (wnum == rd_num)) rd_data = wdata;
`else
`endif
  end

  // 16-bit B-path shift, no carry out.
  always_comb begin
    case (req_q.shift)
      2'b01:   b_shifted = {b_q[14:0], 1'b0};
      2'b10:   b_shifted = {1'b0, b_q[15:1]};
      2'b11:   b_shifted = {b_q[15], b_q[15:1]};
      default: b_shifted = b_q;
    endcase
  end

  // State plus registered valid/busy, derived from the next state so both
  // change on the same edge as the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      valid <= (state_nx == HOLD);
      busy  <= (state_nx != IDLE);
    end
  end

  // Request latch, written only when start is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       req_q <= '0;
    else if (accept) req_q <= '{rn: rn, rm: rm, shift: shift, asel: asel,
                                bsel: bsel, imm: imm};
  end

  // Operand staging registers; later writes to the source register leave them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (load_a) a_q <= rd_data;
      if (load_b) b_q <= rd_data;
    end
  end

  // Register file write port, active in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rf <= '0;
    else if (write) rf[wnum] <= wdata;
  end

  // Operands are functions of registered state only, so they are stable while valid.
  assign Ain = req_q.asel ? 16'h0000 : a_q;
  assign Bin = req_q.bsel ? req_q.imm : b_shifted;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: expected operands are pushed to a queue
// when a fetch is launched and popped when valid is observed.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        reset, start, asel, bsel, write, ready;
  logic [2:0]  rn, rm, wnum;
  logic [1:0]  shift;
  logic [15:0] imm, wdata;
  logic        valid, busy;
  logic [15:0] Ain, Bin;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];

  operand_fetch dut (
    .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .shift(shift),
    .asel(asel), .bsel(bsel), .imm(imm), .write(write), .wnum(wnum),
    .wdata(wdata), .ready(ready), .valid(valid), .busy(busy), .Ain(Ain), .Bin(Bin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Call at a negedge; returns at a negedge.
  task automatic wr(input logic [2:0] n, input logic [15:0] d);
    write = 1'b1; wnum = n; wdata = d;
    @(posedge clk); #1 write = 1'b0;
    @(negedge clk);
  endtask

  // mode 0: plain; 1: write R1=BEEF during READ_A; 2: stray starts in READ_B and HOLD.
  task automatic fetch(input string tag, input logic [2:0] n, input logic [2:0] m,
                       input logic [1:0] sh, input logic as, input logic bs,
                       input logic [15:0] im, input logic [15:0] ea,
                       input logic [15:0] eb, input int hold, input int mode);
    logic [31:0] e;
    int cyc;
    exp_q.push_back({ea, eb});
    start = 1'b1; rn = n; rm = m; shift = sh; asel = as; bsel = bs; imm = im;
    @(posedge clk); #1 start = 1'b0; rn = 3'd4; rm = 3'd4; shift = 2'b00;
    asel = 1'b0; bsel = 1'b0; imm = 16'hDEAD;
    @(negedge clk);
    chk({tag, " busy@k"}, {15'd0, busy}, 16'd1);
    chk({tag, " valid@k"}, {15'd0, valid}, 16'd0);
    if (mode == 1) begin write = 1'b1; wnum = 3'd1; wdata = 16'hBEEF; end
    @(posedge clk); #1 write = 1'b0;
    @(negedge clk);
    chk({tag, " valid@k+1"}, {15'd0, valid}, 16'd0);
    if (mode == 2) begin start = 1'b1; rn = 3'd4; end
    cyc = 0;
    while (!valid && cyc < 8) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 16'(cyc), 16'd1);
    chk({tag, " valid"}, {15'd0, valid}, 16'd1);
    if (exp_q.size() == 0) begin
      checks++;
      $error("FAIL %s scoreboard empty observed=%0d expected=1", tag, exp_q.size());
      e = 32'h0;
    end else e = exp_q.pop_front();
    chk({tag, " Ain"}, Ain, e[31:16]);
    chk({tag, " Bin"}, Bin, e[15:0]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, {15'd0, valid}, 16'd1);
      chk({tag, " hold Ain"}, Ain, e[31:16]);
      chk({tag, " hold Bin"}, Bin, e[15:0]);
    end
    ready = 1'b1;
    if (mode == 2) begin start = 1'b1; rn = 3'd4; end
    @(posedge clk); #1 ready = 1'b0; start = 1'b0;
    @(negedge clk);
    chk({tag, " busy after ready"}, {15'd0, busy}, 16'd0);
    chk({tag, " valid after ready"}, {15'd0, valid}, 16'd0);
    if (mode == 2) begin
      @(negedge clk);
      chk({tag, " start not queued"}, {15'd0, busy}, 16'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rn = '0; rm = '0; shift = '0; asel = 1'b0;
    bsel = 1'b0; imm = '0; write = 1'b0; wnum = '0; wdata = '0; ready = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset valid", {15'd0, valid}, 16'd0);
    chk("reset busy", {15'd0, busy}, 16'd0);
    chk("reset Ain", Ain, 16'h0000);
    chk("reset Bin", Bin, 16'h0000);

    // Basic fetch with a 5-cycle stall.
    wr(3'd1, 16'h0005);
    wr(3'd2, 16'h0003);
    fetch("basic", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0005, 16'h0003, 5, 0);

    // Shift modes on R2=8001.
    wr(3'd2, 16'h8001);
    fetch("shl", 3'd1, 3'd2, 2'b01, 1'b0, 1'b0, 16'h0, 16'h0005, 16'h0002, 0, 0);
    fetch("lsr", 3'd1, 3'd2, 2'b10, 1'b0, 1'b0, 16'h0, 16'h0005, 16'h4000, 0, 0);
    fetch("asr", 3'd1, 3'd2, 2'b11, 1'b0, 1'b0, 16'h0, 16'h0005, 16'hC000, 1, 0);

    // Select paths.
    wr(3'd1, 16'h1234);
    fetch("sel", 3'd1, 3'd2, 2'b00, 1'b1, 1'b1, 16'h00FF, 16'h0000, 16'h00FF, 1, 0);

    // Write/read hazard on R1 during READ_A.
    wr(3'd1, 16'h1111);
`ifdef OPFETCH_BYPASS_EN
    fetch("hazard", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 16'hBEEF, 16'h8001, 2, 1);
`else
    fetch("hazard", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 16'h1111, 16'h8001, 2, 1);
`endif
    fetch("post hazard", 3'd1, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0, 16'hBEEF, 16'hBEEF, 0, 0);

    // Stray starts in READ_B and in HOLD alongside ready.
    wr(3'd4, 16'h4444);
    fetch("ignored start", 3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 16'h0, 16'hBEEF, 16'h8001, 1, 2);

    // Reset in READ_B, then R3 reads back as 0.
    wr(3'd3, 16'hA5A5);
    start = 1'b1; rn = 3'd3; rm = 3'd3;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset valid", {15'd0, valid}, 16'd0);
    chk("midreset busy", {15'd0, busy}, 16'd0);
    chk("midreset Ain", Ain, 16'h0000);
    chk("midreset Bin", Bin, 16'h0000);
    fetch("R3 after reset", 3'd3, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0000, 16'h0000, 0, 0);

    chk("scoreboard drained", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
